controle_multiplicador: RTL and testbench
=========================================

CONTROLE_MULTIPLICADOR -- requirements
Module: controle_multiplicador

Interface
REQ-001 Parameters: none; operand width fixed at 8, product width fixed at 16.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request; sampled only in IDLE.
REQ-005 A  input  8  unsigned multiplicand; captured when Start is accepted.
REQ-006 B  input  8  unsigned multiplier; captured when Start is accepted.
REQ-007 P  output  16  unsigned product; registered, held until next result load.
REQ-008 Busy  output  1  high while state is CALC.
REQ-009 Done  output  1  high for exactly one cycle while state is DONE.

Function
REQ-010 SHALL compute P = A*B by shift-and-add, using the team's 8-bit ripple adder instance (S, Cout) as the only adder.
REQ-011 Internal state SHALL be M[7:0] (multiplicand), Q[7:0] (multiplier/low product), ACC[7:0], C (adder carry), CNT[2:0].
REQ-012 FSM SHALL have states IDLE, CALC, DONE; encoding is free.
REQ-013 IDLE: Start=1 at edge k -> M=A, Q=B, ACC=0, C=0, CNT=0, state=CALC; Start=0 -> stay.
REQ-014 CALC: each edge -> if Q[0]=1 then {C,ACC}=ACC+M (adder Cout into C), else C=0; then {C,ACC,Q} shifted right by one with 0 entering the MSB; CNT increments.
REQ-015 CALC SHALL last exactly 8 edges (k+1..k+8); on the edge where CNT=7, P={ACC,Q} (post-shift) and state=DONE.
REQ-016 DONE: next edge -> state=IDLE unconditionally; Start is ignored in DONE.
REQ-017 Start in CALC or DONE SHALL be ignored; A/B changes after capture SHALL NOT affect the result.
REQ-018 Latency: Done high in the cycle after edge k+8; with Start held, accept edges are k, k+10, k+20...
REQ-019 Product SHALL never overflow 16 bits; adder OV SHALL be left unused.
REQ-020 P SHALL only change on a result load (REQ-015, REQ-028) or reset.

Reset
REQ-021 RST=1 SHALL immediately (without waiting for a clock edge) force state=IDLE, P=0, Busy=0, Done=0, M=Q=ACC=0, C=0, CNT=0.
REQ-022 Reset during CALC SHALL abort the operation; no Done pulse is produced for it.
REQ-023 After RST deasserts, the first rising edge with Start=1 SHALL be accepted.

Configuration
REQ-024 Macro CONTROLE_MULT_ZERO_BYPASS_EN SHALL select the zero-operand bypass.
REQ-025 Defined: in IDLE with Start=1 and (A==0 or B==0) -> P=0, state=DONE directly at edge k, Busy stays 0.
REQ-026 Defined: bypass SHALL produce a single Done pulse in the cycle after edge k; the next accept is possible at edge k+2.
REQ-027 Not defined: zero operands SHALL take the full 8-cycle CALC path (REQ-015) and produce P=0.
REQ-028 The bypass result load SHALL be the only additional P update path.

Verification
REQ-029 Reset; Start at edge k with A=3, B=5 -> Busy edges k+1..k+8, Done one cycle after k+8, P=15 (0x000F).
REQ-030 A=255, B=255 -> P=0xFE01; A=128, B=2 -> P=0x0100; A=1, B=200 -> P=0x00C8.
REQ-031 Start held high with A=2, B=128, then A/B changed during CALC -> first P=0x0100; accepts at k, k+10; Done pulses are 10 cycles apart.
REQ-032 RST pulsed mid-CALC (after edge k+4, between clock edges) -> Busy, Done and P go to 0 immediately; no Done follows; new Start A=7, B=9 -> P=63.
REQ-033 A=0, B=77 with macro -> Done the cycle after edge k, Busy never high, P=0; without macro -> Done after edge k+8, P=0.
REQ-034 Random sweep of 1000 operand pairs, back-to-back -> every P equals A*B; exactly one Done per accepted Start.

Source files
------------

// File: rtl/controle_multiplicador.sv
// Sequential 8x8 unsigned shift-and-add multiplier with IDLE/CALC/DONE control.
// Optional zero-operand bypass: define CONTROLE_MULT_ZERO_BYPASS_EN.
module ripple_adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [8:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[8];
endmodule

module controle_multiplicador (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P,
  output logic        Busy,
  output logic        Done
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  m_q, m_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  acc_q, acc_d;
  logic        c_q, c_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] p_q, p_d;

  logic [7:0]  add_s;
  logic        add_cout;
  logic [7:0]  step_s;
  logic        step_c;

  // C is always cleared by the shift, so as carry-in it contributes nothing.
  ripple_adder8 u_adder (
    .a    (acc_q),
    .b    (m_q),
    .cin  (c_q),
    .s    (add_s),
    .cout (add_cout)
  );

`ifdef CONTROLE_MULT_ZERO_BYPASS_EN
  logic zero_op;
  assign zero_op = (A == 8'd0) || (B == 8'd0);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
`ifdef CONTROLE_MULT_ZERO_BYPASS_EN
          state_d = zero_op ? DONE : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC:    if (cnt_q == 3'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_d    = m_q;
    q_d    = q_q;
    acc_d  = acc_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    p_d    = p_q;
    step_c = q_q[0] ? add_cout : 1'b0;
    step_s = q_q[0] ? add_s : acc_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          m_d   = A;
          q_d   = B;
          acc_d = '0;
          c_d   = 1'b0;
          cnt_d = '0;
`ifdef CONTROLE_MULT_ZERO_BYPASS_EN
          if (zero_op) p_d = '0;
`endif
        end
      end
      CALC: begin
        // {C,ACC,Q} >> 1 after the conditional add; a zero refills C.
        acc_d = {step_c, step_s[7:1]};
        q_d   = {step_s[0], q_q[7:1]};
        c_d   = 1'b0;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) p_d = {acc_d, q_d};
      end
      default: ;
    endcase
  end

  always_comb begin
    Busy = (state_q == CALC);
    Done = (state_q == DONE);
    P    = p_q;
  end
endmodule

// File: tb/tb_controle_multiplicador.sv
// Self-checking bench for controle_multiplicador: directed vectors, corner
// sequences and a randomized back-to-back sweep against a timeline model.
module tb_controle_multiplicador;
  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic [7:0]  A, B;
  logic [15:0] P;
  logic        Busy, Done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_done   = 0;

  // Model: edges elapsed since the accepting edge (-1 when idle).
  int          m_since   = -1;
  logic [15:0] m_prod    = '0;
  logic [15:0] m_p       = '0;
  int          m_accepts = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[7];

  controle_multiplicador dut (
    .CLK   (CLK),
    .RST   (RST),
    .Start (Start),
    .A     (A),
    .B     (B),
    .P     (P),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic is_zero_bypass(input logic [7:0] a, input logic [7:0] b);
`ifdef CONTROLE_MULT_ZERO_BYPASS_EN
    return (a == 8'd0) || (b == 8'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    if (m_since >= 0) begin
      m_since++;
      if (m_since == 8) m_p = m_prod;
      if (m_since > 8) m_since = -1;
    end else if (Start) begin
      m_prod = 16'(A) * 16'(B);
      m_accepts++;
      m_since = 0;
      if (is_zero_bypass(A, B)) begin
        m_since = 8;
        m_p     = '0;
      end
    end
  endtask

  task automatic model_reset();
    m_since = -1;
    m_p     = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    cyc++;
    @(negedge CLK);
    chk("busy", 32'(Busy), 32'(m_since >= 0 && m_since < 8));
    chk("done", 32'(Done), 32'(m_since == 8));
    chk("p",    32'(P),    32'(m_p));
    if (Done) n_done++;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p);
    int n;
    int exp_lat;
    Start = 1'b1;
    A = a;
    B = b;
    tick();
    Start = 1'b0;
    A = ~a;
    B = ~b;
    n = 0;
    while (!Done && n < 30) begin
      tick();
      n++;
    end
    exp_lat = is_zero_bypass(a, b) ? 0 : 8;
    chk("latency", 32'(n), 32'(exp_lat));
    chk("product", 32'(P), 32'(exp_p));
    tick();
    chk("idle_after_done", 32'({Busy, Done}), 32'(0));
  endtask

  initial begin
    int first_done;
    int second_done;
    int n;
    int done_before;
    int acc_before;
    logic [15:0] first_p;

    vecs[0] = '{8'd3,   8'd5,   16'h000F};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd128, 8'd2,   16'h0100};
    vecs[3] = '{8'd1,   8'd200, 16'h00C8};
    vecs[4] = '{8'd0,   8'd77,  16'h0000};
    vecs[5] = '{8'd7,   8'd9,   16'd63};
    vecs[6] = '{8'd77,  8'd0,   16'h0000};

    RST = 1'b1;
    Start = 1'b0;
    A = 8'd0;
    B = 8'd0;
    #1;
    chk("reset_p",    32'(P),    32'(0));
    chk("reset_busy", 32'(Busy), 32'(0));
    chk("reset_done", 32'(Done), 32'(0));
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    tick();

    for (int i = 0; i < 7; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

    // Start held; operands change while calculating.
    Start = 1'b1;
    A = 8'd2;
    B = 8'd128;
    tick();
    A = 8'd255;
    B = 8'd255;
    first_done = -1;
    second_done = -1;
    first_p = '0;
    n = 0;
    while (second_done < 0 && n < 40) begin
      tick();
      n++;
      if (Done && first_done < 0) begin
        first_done = cyc;
        first_p = P;
      end else if (Done && second_done < 0) begin
        second_done = cyc;
      end
    end
    chk("held_first_p", 32'(first_p), 32'h0100);
    chk("held_done_spacing", 32'(second_done - first_done), 32'd10);
    Start = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Asynchronous reset mid-calculation.
    Start = 1'b1;
    A = 8'd15;
    B = 8'd15;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("busy_before_abort", 32'(Busy), 32'(1));
    #1 RST = 1'b1;
    #1;
    chk("abort_busy", 32'(Busy), 32'(0));
    chk("abort_done", 32'(Done), 32'(0));
    chk("abort_p",    32'(P),    32'(0));
    model_reset();
    #1 RST = 1'b0;
    done_before = n_done;
    for (int i = 0; i < 12; i++) tick();
    chk("no_done_after_abort", 32'(n_done - done_before), 32'(0));
    run_op(8'd7, 8'd9, 16'd63);

    // Randomized back-to-back sweep with Start held.
    done_before = n_done;
    acc_before  = m_accepts;
    Start = 1'b1;
    A = 8'($urandom);
    B = 8'($urandom);
    n = 0;
    while ((m_accepts - acc_before) < 1000 && n < 15000) begin
      tick();
      n++;
      A = 8'($urandom);
      B = 8'($urandom);
    end
    Start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("sweep_accepts", 32'(m_accepts - acc_before), 32'd1000);
    chk("sweep_dones",   32'(n_done - done_before),   32'(m_accepts - acc_before));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
